// File: rtl/reg4_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM state encoding and default parameter values.
package reg4_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_HOLD  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dff_4bit_en.sv
// WIDTH-bit storage register with synchronous active-high reset and load enable.
module dff_4bit_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/reg4_rr_arbiter.sv
// Round-robin write arbiter sharing one storage register among NREQ requesters,
// with a one-cycle registered grant and a programmable hold-off after each write.
module reg4_rr_arbiter
    import reg4_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (HOLD > 0) ? CNT_W'(HOLD - 1) : '0;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, owner_n, win, idx;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [NREQ-1:0]  gnt_n;
    logic [WIDTH-1:0] win_data;
    logic             found, accept;
    int               sum;

    // Rotating-priority search: first set request at or after ptr, wrapping.
    // NOTE: every variable written here gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        sum   = 0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_data = wdata[int'(win)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_n   = '0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    accept     = 1'b1;
                    gnt_n[win] = 1'b1;
                    owner_n    = win;
                    ptr_n      = (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_n    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (HOLD > 0) begin
                    state_n = ST_HOLD;
                    cnt_n   = CNT_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            gnt   <= gnt_n;
        end
    end

    dff_4bit_en #(.WIDTH(WIDTH)) u_store (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (win_data),
        .q   (q)
    );

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_reg4_rr_arbiter.sv
// Directed table-driven bench for reg4_rr_arbiter: a HOLD=2 instance driven
// cycle by cycle from a vector table, plus a HOLD=0 instance sequence.
module tb_reg4_rr_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  q;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, rst0 = 1'b1;
    logic [3:0]  req = '0, req0 = '0;
    logic [15:0] wdata = '0, wdata0 = '0;
    logic [3:0]  gnt, gnt0, q, q0;
    logic [1:0]  owner, owner0;
    logic        busy, busy0;

    int tests = 0;
    int fails = 0;

    vec_t vecs[$];
    vec_t vecs0[$];

    always #5 clk = ~clk;

    reg4_rr_arbiter #(.NREQ(4), .WIDTH(4), .HOLD(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .q(q), .owner(owner), .busy(busy)
    );

    reg4_rr_arbiter #(.NREQ(4), .WIDTH(4), .HOLD(0)) u_dut0 (
        .clk(clk), .rst(rst0), .req(req0), .wdata(wdata0),
        .gnt(gnt0), .q(q0), .owner(owner0), .busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] wd,
                       input logic [3:0] g, input logic [3:0] qq, input logic [1:0] o,
                       input logic b);
        vecs.push_back('{r, rq, wd, g, qq, o, b});
    endtask

    task automatic add0(input logic r, input logic [3:0] rq, input logic [15:0] wd,
                        input logic [3:0] g, input logic [3:0] qq, input logic [1:0] o,
                        input logic b);
        vecs0.push_back('{r, rq, wd, g, qq, o, b});
    endtask

    initial begin
        // rst, req, wdata, gnt, q, owner, busy  (outputs after the edge)
        // Reset with all requests pending
        for (int i = 0; i < 3; i++) add(1, 4'hF, 16'h4321, 4'h0, 4'h0, 0, 0);
        // Fairness: 0,1,2,3 at 4-cycle spacing
        add(0, 4'hF, 16'h4321, 4'h1, 4'h1, 0, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h1, 0, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h1, 0, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h1, 0, 0);
        add(0, 4'hF, 16'h4321, 4'h2, 4'h2, 1, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h2, 1, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h2, 1, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h2, 1, 0);
        add(0, 4'hF, 16'h4321, 4'h4, 4'h3, 2, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h3, 2, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h3, 2, 1);
        add(0, 4'hF, 16'h4321, 4'h0, 4'h3, 2, 0);
        add(0, 4'hF, 16'h4321, 4'h8, 4'h4, 3, 1);
        // Wrap: after grant to 3, req=1001 -> 0, then 3
        add(0, 4'h9, 16'h9785, 4'h0, 4'h4, 3, 1);
        add(0, 4'h9, 16'h9785, 4'h0, 4'h4, 3, 1);
        add(0, 4'h9, 16'h9785, 4'h0, 4'h4, 3, 0);
        add(0, 4'h9, 16'h9785, 4'h1, 4'h5, 0, 1);
        add(0, 4'h9, 16'h9785, 4'h0, 4'h5, 0, 1);
        add(0, 4'h9, 16'h9785, 4'h0, 4'h5, 0, 1);
        add(0, 4'h9, 16'h9785, 4'h0, 4'h5, 0, 0);
        add(0, 4'h9, 16'h9785, 4'h8, 4'h9, 3, 1);
        add(0, 4'h0, 16'h9785, 4'h0, 4'h9, 3, 1);
        add(0, 4'h0, 16'h9785, 4'h0, 4'h9, 3, 1);
        add(0, 4'h0, 16'h9785, 4'h0, 4'h9, 3, 0);
        add(0, 4'h0, 16'h9785, 4'h0, 4'h9, 3, 0);
        // Single request on slot 2; data changes after gnt must not reach q early
        add(0, 4'h4, 16'h0A00, 4'h4, 4'hA, 2, 1);
        add(0, 4'h4, 16'h0B00, 4'h0, 4'hA, 2, 1);
        add(0, 4'h4, 16'h0B00, 4'h0, 4'hA, 2, 1);
        add(0, 4'h4, 16'h0B00, 4'h0, 4'hA, 2, 0);
        add(0, 4'h4, 16'h0B00, 4'h4, 4'hB, 2, 1);
        // Reset during the second HOLD cycle, then grant to 1 right after
        add(0, 4'h2, 16'h00C0, 4'h0, 4'hB, 2, 1);
        add(0, 4'h2, 16'h00C0, 4'h0, 4'hB, 2, 1);
        add(1, 4'h2, 16'h00C0, 4'h0, 4'h0, 0, 0);
        add(0, 4'h2, 16'h00C0, 4'h2, 4'hC, 1, 1);
        // Reset during GRANT
        add(1, 4'h2, 16'h00C0, 4'h0, 4'h0, 0, 0);
        add(0, 4'h0, 16'h00C0, 4'h0, 4'h0, 0, 0);

        // HOLD=0 instance: req=0011 held -> 0,1,0 every 2 cycles
        add0(1, 4'h3, 16'h0021, 4'h0, 4'h0, 0, 0);
        add0(0, 4'h3, 16'h0021, 4'h1, 4'h1, 0, 1);
        add0(0, 4'h3, 16'h0021, 4'h0, 4'h1, 0, 0);
        add0(0, 4'h3, 16'h0021, 4'h2, 4'h2, 1, 1);
        add0(0, 4'h3, 16'h0021, 4'h0, 4'h2, 1, 0);
        add0(0, 4'h3, 16'h0021, 4'h1, 4'h1, 0, 1);
        add0(0, 4'h3, 16'h0021, 4'h0, 4'h1, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            req   = vecs[i].req;
            wdata = vecs[i].wdata;
            @(posedge clk);
            #1;
            check($sformatf("h2[%0d].gnt", i),   32'(gnt),   32'(vecs[i].gnt));
            check($sformatf("h2[%0d].q", i),     32'(q),     32'(vecs[i].q));
            check($sformatf("h2[%0d].owner", i), 32'(owner), 32'(vecs[i].owner));
            check($sformatf("h2[%0d].busy", i),  32'(busy),  32'(vecs[i].busy));
        end

        foreach (vecs0[i]) begin
            @(negedge clk);
            rst0   = vecs0[i].rst;
            req0   = vecs0[i].req;
            wdata0 = vecs0[i].wdata;
            @(posedge clk);
            #1;
            check($sformatf("h0[%0d].gnt", i),   32'(gnt0),   32'(vecs0[i].gnt));
            check($sformatf("h0[%0d].q", i),     32'(q0),     32'(vecs0[i].q));
            check($sformatf("h0[%0d].owner", i), 32'(owner0), 32'(vecs0[i].owner));
            check($sformatf("h0[%0d].busy", i),  32'(busy0),  32'(vecs0[i].busy));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg4_rr_arbiter.md
# reg4_rr_arbiter

Round-robin write arbiter that shares one WIDTH-bit D-flip-flop storage register among NREQ requesters. The block accepts one write per arbitration, latches the winner's data into the register, and reports the write back with a one-cycle grant. It then holds the register stable for a programmable number of cycles before the next write. It sits between independent producers and the shared 4-bit state register.

## Interface
- NREQ, 4: number of requesters, ≥2.
- WIDTH, 4: data and register width.
- HOLD, 2: stable cycles after each grant before the next arbitration, ≥0.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  bit i high = requester i wants to write. Held high until it sees gnt[i].
- wdata  in  NREQ*WIDTH  requester i data on [i*WIDTH +: WIDTH].
- gnt  out  NREQ  registered, one-hot or zero. High for exactly one cycle per accepted write.
- q  out  WIDTH  stored register value.
- owner  out  $clog2(NREQ)  index of the last accepted writer.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - GRANT: one cycle, gnt asserted.
  - HOLD: HOLD cycles.
- IDLE with req ≠ 0 at an edge:
  - Winner w = first set bit searching ptr, ptr+1, … with modulo-NREQ wrap.
  - At that same edge: q ← wdata[w], owner ← w, gnt ← onehot(w), ptr ← (w+1) mod NREQ, state ← GRANT.
- IDLE with req = 0: remain in IDLE, with gnt = 0.
- GRANT → HOLD when HOLD > 0 (down-counter loaded with HOLD−1); otherwise GRANT → IDLE.
- GRANT and HOLD ignore req entirely. A requester still holding req during its gnt cycle is not double-granted.
- HOLD → IDLE when the counter reaches 0; otherwise the counter decrements.
- q and owner change only on acceptance. Otherwise they hold their value.
- Reset values: q = 0, owner = 0, gnt = 0, busy = 0, ptr = 0, counter = 0, state = IDLE.
- Reset has priority over every transition, including mid-GRANT and mid-HOLD. A pending write is not re-issued after reset.

## Timing
- Latency: req sampled high in IDLE at edge k → q, owner and gnt valid after edge k. gnt falls after edge k+1.
- busy is high from after edge k through the edge that returns to IDLE, i.e. 1+HOLD cycles.
- Next acceptance occurs no earlier than edge k+2+HOLD. Peak throughput is one write per 2+HOLD cycles.
- No combinational path from req or wdata to any output.
- Requesters may change wdata only after seeing their gnt. wdata is sampled only at the acceptance edge.

## Structure
- Package reg4_arb_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_HOLD = 2'd2;
  - default parameter constants.
- Sub-module dff_4bit_en is the WIDTH-parameterised storage register with sync active-high reset and load enable.
  - Ports: clk, rst, en, d, q.
  - Instantiated once for q.
- The arbiter top holds ptr, the FSM, the HOLD counter and the rotate-priority search.

## Test plan
All scenarios use NREQ = 4, WIDTH = 4, HOLD = 2 unless stated.
- **Reset with requests pending:** rst high for 3 edges with req = 4'b1111 → gnt = 0, q = 0, owner = 0, busy = 0 throughout. First grant goes to index 0 at the first edge with rst low.
- **Single request:** req = 4'b0100, slot 2 data = 4'hA in IDLE at edge k → q = 4'hA and owner = 2 after edge k. gnt = 4'b0100 for one cycle. busy high 3 cycles. req still high yields the next grant at edge k+4.
- **Fairness:** all req held high with data 1, 2, 3, 4 → grant order 0, 1, 2, 3, 0 at 4-cycle spacing. q sequence is 1, 2, 3, 4, 1.
- **Wrap:** after a grant to 3, req = 4'b1001 → grant 0. The next arbitration with req = 4'b1001 → grant 3.
- **Reset mid-operation:** rst asserted during the second HOLD cycle → after that edge all outputs are 0 and state is IDLE. With req = 4'b0010 held, the grant to 1 occurs at the first edge with rst low.
- **HOLD = 0 instance:** req = 4'b0011 held → alternating grants 0, 1, 0 every 2 cycles. busy high exactly during the gnt cycles.
